alu_exec_unit: RTL and testbench
================================

Name: alu_exec_unit

Overview:
Multi-cycle ALU execution unit that consumes the 4-bit ALU control code produced by the ALU decoder and computes the result.
- Single-cycle ops (ADD/SUB/SLT/SLTU/logic) complete one cycle after acceptance.
- Shifts run iteratively, SHIFT_STEP bit positions per cycle, so there is no barrel shifter.
- Sits between decode and writeback. Valid/ready on both sides; single-entry output register.

Parameters:
DATA_WIDTH, 32, operand/result width. Fixed at 32 for RV32I.
SHIFT_STEP, 1, bit positions shifted per SHIFT cycle. Legal values: 1, 2, 4, 8, 16.

Ports:
clk_i  input  1  clock, rising edge
rst_n_i  input  1  asynchronous active-low reset
flush_i  input  1  synchronous abort of in-flight op and output entry
valid_i  input  1  operands + control valid
ready_o  output  1  unit can accept this cycle
alu_control_i  input  4  op code: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 SRL, 6 SRA, 7 OR, 8 XOR, 9 AND, A ZERO
a_i  input  32  operand A
b_i  input  32  operand B; b_i[4:0] is the shift amount
valid_o  output  1  result valid
ready_i  input  1  downstream accepts result
result_o  output  32  result
zero_o  output  1  result_o == 0, for branch compare
illegal_o  output  1  control code was B..F

Behaviour:
- Reset (rst_n_i low, async): state=IDLE, valid_o=0, result_o=0, zero_o=0, illegal_o=0, internal shift counter=0.
- States: IDLE, SHIFT, HOLD.
- Acceptance occurs when valid_i && ready_o on a rising edge. Operands and code are captured; inputs are don't-care afterwards.
- ready_o = (state==IDLE) && (!valid_o || ready_i). Combinational, and independent of valid_i.
- Non-shift op, or shift with shamt==0:
  - On accept, the result is written to the output register.
  - valid_o=1 the next cycle (latency 1). State stays IDLE.
- Shift with shamt>0:
  - On accept, go to SHIFT and load the working register with a_i and the remaining count with shamt.
  - Each SHIFT cycle shifts by min(SHIFT_STEP, remaining) and decrements remaining by the same amount.
  - When remaining reaches 0, the result is written and valid_o=1 the next cycle.
  - State then moves to HOLD if ready_i is low, otherwise to IDLE.
  - Total latency = 1 + ceil(shamt/SHIFT_STEP) cycles, accept to valid_o.
- Fill bits:
  - SLL fills with 0.
  - SRL fills with 0.
  - SRA fills with the captured a[31].
- Arithmetic:
  - ADD and SUB are modulo 2^32, with no carry or overflow output.
  - SLT is a signed compare and SLTU an unsigned compare; the result is {31'b0, lt}.
  - ZERO (code A) gives result 0.
- Illegal codes B..F: result 0, illegal_o=1. Latency 1.
- illegal_o and zero_o are registered with result_o and valid only while valid_o=1.
- Output hold: while valid_o && !ready_i, result_o, zero_o and illegal_o are stable and no new op is accepted.
  - HOLD exits to IDLE on ready_i.
- In IDLE with valid_o && ready_i && valid_i:
  - The old result is consumed and the new op is accepted in the same cycle.
  - For a non-shift op, valid_o stays 1 with the new result (back-to-back, one op per cycle).
  - For a shift, valid_o drops the next cycle until the shift completes.
- flush_i (synchronous, highest priority after reset):
  - Next state=IDLE and valid_o=0.
  - The in-flight shift is discarded and no acceptance occurs that cycle.
  - ready_o is forced 0 while flush_i=1.
- Reset asserted mid-SHIFT or mid-HOLD: immediate return to reset values, with no partial result visible.
- Assertions:
  - SHIFT_STEP is a legal value, checked at elaboration.
  - The remaining count never underflows.
  - Outputs are stable under back-pressure.

Test Plan:
- ADD, single cycle: a=0x7FFFFFFF, b=1, code 0, ready_i=1 -> valid_o one cycle later, result 0x80000000, zero_o=0. SUB with a=b=5 -> result 0, zero_o=1.
- Signed vs unsigned compare: a=0xFFFFFFFF, b=1. SLT (code 3) -> result 1; SLTU (code 4) -> result 0.
- SRA, SHIFT_STEP=1: a=0x80000000, b=31, code 6 -> valid_o 32 cycles after accept, result 0xFFFFFFFF, ready_o=0 throughout. SRL on the same operands -> result 0x00000001.
- SLL, SHIFT_STEP=4: a=0x00000001, b=7 -> latency 1+2=3, result 0x00000080. shamt=0 -> latency 1, result=a.
- Back-pressure and back-to-back: ready_i=0 for 5 cycles after an XOR result (a=0xF0F0F0F0, b=0xFFFF0000 -> 0x0F0FF0F0) -> result stable, ready_o=0. Then release ready_i with valid_i held on AND -> new result on the following cycle, no bubble.
- Flush, reset and illegal code:
  - flush_i mid-SLL at cycle 3 of 10 -> valid_o stays 0, ready_o=1 the next cycle.
  - rst_n_i low mid-SHIFT -> all outputs 0 immediately.
  - Code 0xC -> result 0, illegal_o=1, latency 1.

Source files
------------

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - multi-cycle RV32I ALU execution unit with iterative shifter
//
// Ports:
//   clk_i, rst_n_i          clock (rising edge), asynchronous active-low reset
//   flush_i                 synchronous abort of in-flight shift and output entry
//   valid_i / ready_o       operand handshake (ready_o is independent of valid_i)
//   alu_control_i           0 ADD,1 SUB,2 SLL,3 SLT,4 SLTU,5 SRL,6 SRA,7 OR,8 XOR,9 AND,A ZERO
//   a_i, b_i                operands; b_i[4:0] is the shift amount
//   valid_o / ready_i       result handshake, single-entry output register
//   result_o, zero_o        result and result==0 flag
//   illegal_o               control code was B..F
module alu_exec_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int SHIFT_STEP = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  flush_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [3:0]            alu_control_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic                  zero_o,
    output logic                  illegal_o
);

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_SLL  = 4'h2;
    localparam logic [3:0] OP_SLT  = 4'h3;
    localparam logic [3:0] OP_SLTU = 4'h4;
    localparam logic [3:0] OP_SRL  = 4'h5;
    localparam logic [3:0] OP_SRA  = 4'h6;
    localparam logic [3:0] OP_OR   = 4'h7;
    localparam logic [3:0] OP_XOR  = 4'h8;
    localparam logic [3:0] OP_AND  = 4'h9;
    localparam logic [3:0] OP_ZERO = 4'hA;

    localparam logic [4:0] STEP = 5'(SHIFT_STEP);

    generate
        if (!(SHIFT_STEP == 1 || SHIFT_STEP == 2 || SHIFT_STEP == 4 ||
              SHIFT_STEP == 8 || SHIFT_STEP == 16)) begin : g_bad_step
            $error("alu_exec_unit: SHIFT_STEP must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_HOLD} state_t;

    state_t                state_q,   state_d;
    logic                  valid_q,   valid_d;
    logic [DATA_WIDTH-1:0] result_q,  result_d;
    logic                  zero_q,    zero_d;
    logic                  illegal_q, illegal_d;
    logic [DATA_WIDTH-1:0] work_q,    work_d;
    logic [4:0]            rem_q,     rem_d;
    logic [3:0]            ctrl_q,    ctrl_d;

    logic                  accept;
    logic                  is_shift;
    logic [4:0]            shamt;
    logic [DATA_WIDTH-1:0] alu_res;
    logic                  illegal_res;
    logic [4:0]            step_amt;
    logic [DATA_WIDTH-1:0] shifted;

    assign ready_o  = !flush_i && (state_q == S_IDLE) && (!valid_q || ready_i);
    assign accept   = valid_i && ready_o;
    assign shamt    = b_i[4:0];
    assign is_shift = (alu_control_i == OP_SLL) || (alu_control_i == OP_SRL) ||
                      (alu_control_i == OP_SRA);

    // Single-cycle datapath; a shift by zero passes operand A straight through.
    always_comb begin
        alu_res     = '0;
        illegal_res = 1'b0;
        case (alu_control_i)
            OP_ADD:  alu_res = a_i + b_i;
            OP_SUB:  alu_res = a_i - b_i;
            OP_SLL,
            OP_SRL,
            OP_SRA:  alu_res = a_i;
            OP_SLT:  alu_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            OP_SLTU: alu_res = {{(DATA_WIDTH-1){1'b0}}, (a_i < b_i)};
            OP_OR:   alu_res = a_i | b_i;
            OP_XOR:  alu_res = a_i ^ b_i;
            OP_AND:  alu_res = a_i & b_i;
            OP_ZERO: alu_res = '0;
            default: illegal_res = 1'b1;
        endcase
    end

    // One iteration moves at most STEP bits; the mux over constant shifts
    // keeps the shifter to SHIFT_STEP taps instead of a full barrel.
    assign step_amt = (rem_q < STEP) ? rem_q : STEP;

    always_comb begin
        shifted = work_q;
        for (int k = 1; k <= SHIFT_STEP; k++) begin
            if (step_amt == 5'(k)) begin
                case (ctrl_q)
                    OP_SLL:  shifted = work_q << k;
                    OP_SRL:  shifted = work_q >> k;
                    default: shifted = DATA_WIDTH'($signed(work_q) >>> k);
                endcase
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        valid_d   = valid_q;
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
        work_d    = work_q;
        rem_d     = rem_q;
        ctrl_d    = ctrl_q;

        // Downstream takes the held result; a same-cycle writeback below re-arms it.
        if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end

        if (flush_i) begin
            state_d = S_IDLE;
            valid_d = 1'b0;
            rem_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        ctrl_d = alu_control_i;
                        if (is_shift && (shamt != 5'd0)) begin
                            state_d = S_SHIFT;
                            work_d  = a_i;
                            rem_d   = shamt;
                        end else begin
                            result_d  = alu_res;
                            zero_d    = (alu_res == '0);
                            illegal_d = illegal_res;
                            valid_d   = 1'b1;
                        end
                    end
                end
                S_SHIFT: begin
                    work_d = shifted;
                    rem_d  = rem_q - step_amt;
                    if (rem_q == step_amt) begin
                        result_d  = shifted;
                        zero_d    = (shifted == '0);
                        illegal_d = 1'b0;
                        valid_d   = 1'b1;
                        state_d   = ready_i ? S_IDLE : S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (ready_i) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= S_IDLE;
            valid_q   <= 1'b0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
            work_q    <= '0;
            rem_q     <= '0;
            ctrl_q    <= '0;
        end else begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
            work_q    <= work_d;
            rem_q     <= rem_d;
            ctrl_q    <= ctrl_d;
        end
    end

    assign valid_o   = valid_q;
    assign result_o  = result_q;
    assign zero_o    = valid_q && zero_q;
    assign illegal_o = valid_q && illegal_q;

    a_rem_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        (state_q == S_SHIFT) |-> (rem_q != 5'd0));

    a_hold_stable: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        (valid_o && !ready_i && !flush_i) |=>
        (valid_o && $stable(result_o) && $stable(zero_o) && $stable(illegal_o)));

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - bench for alu_exec_unit at SHIFT_STEP 1 and 4
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        v_i   [2];
    logic        r_i   [2];
    logic [3:0]  c_i   [2];
    logic [31:0] a_i   [2];
    logic [31:0] b_i   [2];
    logic        rdy_o [2];
    logic        vo    [2];
    logic [31:0] res_o [2];
    logic        z_o   [2];
    logic        il_o  [2];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_exec_unit #(.DATA_WIDTH(32), .SHIFT_STEP(1)) u_dut_s1 (
        .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush),
        .valid_i(v_i[0]), .ready_o(rdy_o[0]), .alu_control_i(c_i[0]),
        .a_i(a_i[0]), .b_i(b_i[0]), .valid_o(vo[0]), .ready_i(r_i[0]),
        .result_o(res_o[0]), .zero_o(z_o[0]), .illegal_o(il_o[0])
    );

    alu_exec_unit #(.DATA_WIDTH(32), .SHIFT_STEP(4)) u_dut_s4 (
        .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush),
        .valid_i(v_i[1]), .ready_o(rdy_o[1]), .alu_control_i(c_i[1]),
        .a_i(a_i[1]), .b_i(b_i[1]), .valid_o(vo[1]), .ready_i(r_i[1]),
        .result_o(res_o[1]), .zero_o(z_o[1]), .illegal_o(il_o[1])
    );

    function automatic logic [31:0] ref_alu(logic [3:0] op, logic [31:0] a, logic [31:0] b);
        int unsigned sh;
        sh = b[4:0];
        case (op)
            4'h0: return a + b;
            4'h1: return a - b;
            4'h2: return a << sh;
            4'h3: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'h4: return (a < b) ? 32'd1 : 32'd0;
            4'h5: return a >> sh;
            4'h6: return 32'($signed(a) >>> sh);
            4'h7: return a | b;
            4'h8: return a ^ b;
            4'h9: return a & b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int ref_lat(logic [3:0] op, logic [31:0] b, int step);
        int sh;
        sh = int'(b[4:0]);
        if ((op == 4'h2 || op == 4'h5 || op == 4'h6) && sh != 0)
            return 1 + (sh + step - 1) / step;
        return 1;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(int d);
        int w;
        w = 0;
        @(negedge clk);
        while (!rdy_o[d] && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk("ready_wait", 32'(w < 200), 32'd1);
    endtask

    // Accept one op on DUT d, then check latency, result and flags.
    task automatic run_op(int d, logic [3:0] op, logic [31:0] a, logic [31:0] b, string tag);
        int cyc, step, lat;
        logic [31:0] exp;
        bit rdy_low;
        step = (d == 0) ? 1 : 4;
        exp  = ref_alu(op, a, b);
        lat  = ref_lat(op, b, step);
        wait_ready(d);
        v_i[d] = 1'b1; c_i[d] = op; a_i[d] = a; b_i[d] = b;
        @(posedge clk);
        #1;
        v_i[d] = 1'b0; a_i[d] = $urandom; b_i[d] = $urandom; c_i[d] = 4'($urandom);
        cyc = 1;
        rdy_low = 1'b1;
        while (!vo[d] && cyc < 100) begin
            if (rdy_o[d]) rdy_low = 1'b0;
            @(posedge clk);
            #1;
            cyc++;
        end
        chk({tag, "_lat"}, 32'(cyc), 32'(lat));
        chk({tag, "_res"}, res_o[d], exp);
        chk({tag, "_zero"}, 32'(z_o[d]), 32'(exp == 32'd0));
        chk({tag, "_ill"}, 32'(il_o[d]), 32'(op > 4'hA));
        if (lat > 1) chk({tag, "_busy"}, 32'(rdy_low), 32'd1);
    endtask

    initial begin
        bit ok;
        logic [3:0] rop;
        v_i = '{1'b0, 1'b0};
        r_i = '{1'b1, 1'b1};
        c_i = '{4'h0, 4'h0};
        a_i = '{32'h0, 32'h0};
        b_i = '{32'h0, 32'h0};

        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_valid", 32'(vo[d]), 32'd0);
            chk("rst_result", res_o[d], 32'd0);
            chk("rst_zero", 32'(z_o[d]), 32'd0);
            chk("rst_ill", 32'(il_o[d]), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_ready", 32'(rdy_o[0]), 32'd1);

        run_op(0, 4'h0, 32'h7FFF_FFFF, 32'h1, "add");
        run_op(0, 4'h1, 32'd5, 32'd5, "sub");
        run_op(0, 4'h3, 32'hFFFF_FFFF, 32'h1, "slt");
        run_op(0, 4'h4, 32'hFFFF_FFFF, 32'h1, "sltu");
        run_op(0, 4'h6, 32'h8000_0000, 32'd31, "sra31");
        run_op(0, 4'h5, 32'h8000_0000, 32'd31, "srl31");
        run_op(0, 4'hC, 32'h1234_5678, 32'h9, "illegal");
        run_op(1, 4'h2, 32'h1, 32'd7, "sll7_s4");
        run_op(1, 4'h2, 32'hDEAD_BEEF, 32'h20, "sll0_s4");
        run_op(1, 4'h6, 32'h8000_0000, 32'd31, "sra31_s4");

        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 30; i++) begin
                rop = 4'($urandom_range(0, 15));
                run_op(d, rop, $urandom, $urandom, "rand");
            end
        end

        // Back-pressure on XOR, then AND accepted in the release cycle.
        r_i[0] = 1'b0;
        run_op(0, 4'h8, 32'hF0F0_F0F0, 32'hFFFF_0000, "xor");
        @(negedge clk);
        v_i[0] = 1'b1; c_i[0] = 4'h9; a_i[0] = 32'hFF00_FF00; b_i[0] = 32'h0FF0_0FF0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp_result", res_o[0], 32'h0F0F_F0F0);
            chk("bp_valid", 32'(vo[0]), 32'd1);
            chk("bp_ready", 32'(rdy_o[0]), 32'd0);
        end
        @(negedge clk);
        r_i[0] = 1'b1;
        #1;
        chk("b2b_ready", 32'(rdy_o[0]), 32'd1);
        @(posedge clk);
        #1;
        v_i[0] = 1'b0;
        chk("b2b_valid", 32'(vo[0]), 32'd1);
        chk("b2b_result", res_o[0], 32'h0F00_0F00);

        // Shift finishing into back-pressure parks in HOLD.
        r_i[1] = 1'b0;
        run_op(1, 4'h5, 32'hF000_0000, 32'd9, "srl_hold");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("hold_result", res_o[1], 32'h0078_0000);
            chk("hold_ready", 32'(rdy_o[1]), 32'd0);
        end
        @(negedge clk);
        r_i[1] = 1'b1;
        @(posedge clk);
        #1;
        chk("hold_drain", 32'(vo[1]), 32'd0);
        chk("hold_idle_ready", 32'(rdy_o[1]), 32'd1);

        // Flush in the third cycle of a 10-bit SLL.
        wait_ready(0);
        v_i[0] = 1'b1; c_i[0] = 4'h2; a_i[0] = 32'h1; b_i[0] = 32'd10;
        @(posedge clk);
        #1;
        v_i[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        flush = 1'b1;
        #1;
        chk("flush_ready_low", 32'(rdy_o[0]), 32'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        #1;
        chk("flush_valid", 32'(vo[0]), 32'd0);
        chk("flush_ready", 32'(rdy_o[0]), 32'd1);
        ok = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (vo[0]) ok = 1'b0;
        end
        chk("flush_no_result", 32'(ok), 32'd1);

        // Reset mid-shift after a visible nonzero result.
        run_op(0, 4'h0, 32'd1, 32'd2, "pre_rst");
        wait_ready(0);
        v_i[0] = 1'b1; c_i[0] = 4'h2; a_i[0] = 32'h3; b_i[0] = 32'd20;
        @(posedge clk);
        #1;
        v_i[0] = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(vo[0]), 32'd0);
        chk("mid_rst_result", res_o[0], 32'd0);
        chk("mid_rst_zero", 32'(z_o[0]), 32'd0);
        chk("mid_rst_ill", 32'(il_o[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            #1;
            if (vo[0] || res_o[0] != 32'd0) ok = 1'b0;
        end
        chk("post_rst_quiet", 32'(ok), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
